// File: rtl/elevador_pkg.sv
// Shared types and helpers for the 4-floor elevator controller.
// Floor codes, FSM states, travel direction and masks for calls above or below a floor.
package elevador_pkg;

  localparam int N_ANDARES = 4;

  localparam logic [1:0] ANDAR_T = 2'd0;
  localparam logic [1:0] ANDAR_1 = 2'd1;
  localparam logic [1:0] ANDAR_2 = 2'd2;
  localparam logic [1:0] ANDAR_3 = 2'd3;

  typedef enum logic [2:0] {
    PARADO,
    SUBINDO,
    DESCENDO,
    PORTA_ABERTA,
    PORTA_FECHANDO
  } estado_t;

  typedef enum logic {
    SOBE,
    DESCE
  } dir_t;

  // Bits strictly above the given floor.
  function automatic logic [N_ANDARES-1:0] mascaraAcima(input logic [1:0] andarRef);
    logic [N_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < N_ANDARES; i++) m[i] = (i > int'(andarRef));
    return m;
  endfunction

  // Bits strictly below the given floor.
  function automatic logic [N_ANDARES-1:0] mascaraAbaixo(input logic [1:0] andarRef);
    logic [N_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < N_ANDARES; i++) m[i] = (i < int'(andarRef));
    return m;
  endfunction

endpackage

// File: rtl/elevador_temporizador.sv
// Loadable down-counter shared by the travel and door phases.
// fim flags the last cycle of a loaded interval (count equals 1).
module elevador_temporizador #(
  parameter int LARGURA = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carga,
  input  logic [LARGURA-1:0] valor,
  output logic               fim
);

  logic [LARGURA-1:0] contagem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (carga) begin
      contagem <= valor;
    end else if (contagem != '0) begin
      contagem <= contagem - 1'b1;
    end
  end

  assign fim = (contagem == LARGURA'(1));

endmodule

// File: rtl/elevador_controle.sv
// Elevator car controller: latched calls, floor register, SCAN direction policy
// and Moore one-hot motor/door commands with timed travel and door phases.
module elevador_controle
  import elevador_pkg::*;
#(
  parameter int N_ANDARES = elevador_pkg::N_ANDARES,
  parameter int T_VIAGEM  = 4,
  parameter int T_PORTA   = 3,
  parameter int T_FECHA   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_ANDARES-1:0] chamadas,
  output logic [1:0]           andar,
  output logic [N_ANDARES-1:0] pendentes,
  output logic                 Su,
  output logic                 De,
  output logic                 PA,
  output logic                 PF
);

  localparam int T_MAX_VP = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
  localparam int T_MAX    = (T_MAX_VP > T_FECHA) ? T_MAX_VP : T_FECHA;
  localparam int LARGURA  = $clog2(T_MAX + 1);

  estado_t estado, proxEstado;
  dir_t    dir, proxDir;
  logic [1:0]           proxAndar;
  logic [N_ANDARES-1:0] proxPendentes, pendAgora, bitAndar, bitNovo, limpa, ignora;
  logic                 acima, abaixo, carga, fim;
  logic [LARGURA-1:0]   valor;

  elevador_temporizador #(.LARGURA(LARGURA)) uTemporizador (
    .clk  (clk),
    .rst_n(rst_n),
    .carga(carga),
    .valor(valor),
    .fim  (fim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= PARADO;
      andar     <= ANDAR_T;
      pendentes <= '0;
      dir       <= SOBE;
    end else begin
      estado    <= proxEstado;
      andar     <= proxAndar;
      pendentes <= proxPendentes;
      dir       <= proxDir;
    end
  end

  // Arrival decisions also see calls arriving in the same cycle; PARADO only sees latched ones.
  always_comb begin
    proxEstado = estado;
    proxAndar  = andar;
    proxDir    = dir;
    carga      = 1'b0;
    valor      = '0;
    limpa      = '0;
    ignora     = '0;
    bitNovo    = '0;
    pendAgora  = pendentes | chamadas;
    bitAndar   = N_ANDARES'(1) << andar;
    acima      = |(pendentes & mascaraAcima(andar));
    abaixo     = |(pendentes & mascaraAbaixo(andar));

    case (estado)
      PARADO: begin
        if (|(pendentes & bitAndar)) begin
          proxEstado = PORTA_ABERTA;
          limpa      = bitAndar;
          carga      = 1'b1;
          valor      = LARGURA'(T_PORTA);
        end else if (acima && (dir == SOBE || !abaixo)) begin
          proxEstado = SUBINDO;
          proxDir    = SOBE;
          carga      = 1'b1;
          valor      = LARGURA'(T_VIAGEM);
        end else if (abaixo) begin
          proxEstado = DESCENDO;
          proxDir    = DESCE;
          carga      = 1'b1;
          valor      = LARGURA'(T_VIAGEM);
        end
      end
      SUBINDO, DESCENDO: begin
        if (fim) begin
          proxAndar = (estado == SUBINDO) ? andar + 2'd1 : andar - 2'd1;
          bitNovo   = N_ANDARES'(1) << proxAndar;
          if (|(pendAgora & bitNovo)) begin
            proxEstado = PORTA_ABERTA;
            limpa      = bitNovo;
            carga      = 1'b1;
            valor      = LARGURA'(T_PORTA);
          end else if (|(pendAgora & ((estado == SUBINDO) ? mascaraAcima(proxAndar)
                                                          : mascaraAbaixo(proxAndar)))) begin
            carga = 1'b1;
            valor = LARGURA'(T_VIAGEM);
          end else begin
            proxEstado = PARADO;
          end
        end
      end
      PORTA_ABERTA: begin
        if (|(chamadas & bitAndar)) begin
          ignora = bitAndar;
          carga  = 1'b1;
          valor  = LARGURA'(T_PORTA);
        end else if (fim) begin
          proxEstado = PORTA_FECHANDO;
          carga      = 1'b1;
          valor      = LARGURA'(T_FECHA);
        end
      end
      PORTA_FECHANDO: begin
        if (|(chamadas & bitAndar)) begin
          ignora     = bitAndar;
          proxEstado = PORTA_ABERTA;
          carga      = 1'b1;
          valor      = LARGURA'(T_PORTA);
        end else if (fim) begin
          proxEstado = PARADO;
        end
      end
      default: proxEstado = PARADO;
    endcase

    proxPendentes = (pendentes | (chamadas & ~ignora)) & ~limpa;
  end

  assign Su = (estado == SUBINDO);
  assign De = (estado == DESCENDO);
  assign PA = (estado == PORTA_ABERTA);
  assign PF = (estado == PORTA_FECHANDO);

endmodule

// File: tb/tb_elevador_controle.sv
// Directed self-checking bench for elevador_controle with default timing (4/3/2).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_elevador_controle;

  logic       clk;
  logic       rst_n;
  logic [3:0] chamadas;
  logic [1:0] andar;
  logic [3:0] pendentes;
  logic       Su, De, PA, PF;
  logic [9:0] vista;

  int checks   = 0;
  int failures = 0;

  elevador_controle dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .chamadas (chamadas),
    .andar    (andar),
    .pendentes(pendentes),
    .Su       (Su),
    .De       (De),
    .PA       (PA),
    .PF       (PF)
  );

  assign vista = {pendentes, Su, De, PA, PF, andar};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observado,
                             input logic [31:0] esperado);
    checks++;
    if (observado !== esperado) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observado, esperado);
    end
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyReset();
    rst_n    = 1'b0;
    chamadas = 4'b0000;
    waitNeg(2);
    checkOutput("reset_state", 32'(vista), 32'h0);
    rst_n = 1'b1;
    waitNeg(1);
  endtask

  task automatic applyStimulus(input logic [3:0] botoes, input int ciclos);
    chamadas = botoes;
    waitNeg(ciclos);
    chamadas = 4'b0000;
  endtask

  // Expected {pendentes, Su, De, PA, PF, andar} k edges after a single call for floor 2.
  function automatic logic [9:0] esperadoAndar2(input int k);
    if (k == 1)       return {4'b0100, 4'b0000, 2'd0};
    else if (k <= 5)  return {4'b0100, 4'b1000, 2'd0};
    else if (k <= 9)  return {4'b0100, 4'b1000, 2'd1};
    else if (k <= 12) return {4'b0000, 4'b0010, 2'd2};
    else if (k <= 14) return {4'b0000, 4'b0001, 2'd2};
    else              return {4'b0000, 4'b0000, 2'd2};
  endfunction

  logic [1:0] andarRec [6];
  logic [1:0] movRec   [6];
  logic [1:0] andarEsp [6];
  logic [1:0] movEsp   [6];
  logic [1:0] prevAndar;
  logic [1:0] prevMov;
  int         nRec;

  initial begin
    rst_n    = 1'b0;
    chamadas = 4'b0000;

    // Single call to floor 2: full travel and door cycle.
    applyReset();
    applyStimulus(4'b0100, 1);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) waitNeg(1);
      checkOutput($sformatf("andar2_k%0d", k), 32'(vista), 32'(esperadoAndar2(k)));
    end

    // Call for the current floor while parked.
    applyReset();
    applyStimulus(4'b0001, 1);
    checkOutput("atual_latch", 32'(vista), 32'({4'b0001, 4'b0000, 2'd0}));
    waitNeg(1);
    checkOutput("atual_abre", 32'(vista), 32'({4'b0000, 4'b0010, 2'd0}));

    // Door reopen during the closing phase at floor 2.
    applyReset();
    applyStimulus(4'b0100, 1);
    waitNeg(12);
    checkOutput("reabre_pf", 32'(vista), 32'({4'b0000, 4'b0001, 2'd2}));
    applyStimulus(4'b0100, 1);
    checkOutput("reabre_pa1", 32'(vista), 32'({4'b0000, 4'b0010, 2'd2}));
    waitNeg(1);
    checkOutput("reabre_pa2", 32'(vista), 32'({4'b0000, 4'b0010, 2'd2}));
    waitNeg(1);
    checkOutput("reabre_pa3", 32'(vista), 32'({4'b0000, 4'b0010, 2'd2}));
    waitNeg(1);
    checkOutput("reabre_fecha", 32'(vista), 32'({4'b0000, 4'b0001, 2'd2}));
    waitNeg(2);
    checkOutput("reabre_parado", 32'(vista), 32'({4'b0000, 4'b0000, 2'd2}));

    // Door hold: current-floor call held high keeps the door open.
    chamadas = 4'b0100;
    waitNeg(2);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("segura_%0d", i), 32'(vista), 32'({4'b0000, 4'b0010, 2'd2}));
      if (i == 9) chamadas = 4'b0000;
      else waitNeg(1);
    end
    waitNeg(1);
    checkOutput("segura_solta1", 32'(vista), 32'({4'b0000, 4'b0010, 2'd2}));
    waitNeg(1);
    checkOutput("segura_solta2", 32'(vista), 32'({4'b0000, 4'b0010, 2'd2}));
    waitNeg(1);
    checkOutput("segura_fecha", 32'(vista), 32'({4'b0000, 4'b0001, 2'd2}));

    // SCAN: go to floor 1, latch floors 3 and 0 while moving up.
    applyReset();
    applyStimulus(4'b0010, 1);
    waitNeg(1);
    checkOutput("scan_sobe", 32'(Su), 32'(1'b1));
    applyStimulus(4'b1001, 1);
    checkOutput("scan_pend", 32'(pendentes), 32'(4'b1011));
    andarEsp = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    movEsp   = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    prevAndar = andar;
    prevMov   = {Su, De};
    nRec      = 0;
    for (int c = 0; c < 80 && nRec < 6; c++) begin
      waitNeg(1);
      if (andar != prevAndar) begin
        andarRec[nRec] = andar;
        movRec[nRec]   = prevMov;
        nRec++;
      end
      prevAndar = andar;
      prevMov   = {Su, De};
    end
    checkOutput("scan_paradas", 32'(nRec), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < nRec) begin
        checkOutput($sformatf("scan_andar%0d", i), 32'(andarRec[i]), 32'(andarEsp[i]));
        checkOutput($sformatf("scan_mov%0d", i), 32'(movRec[i]), 32'(movEsp[i]));
      end
    end
    checkOutput("scan_fim", 32'(vista), 32'({4'b0000, 4'b0010, 2'd0}));

    // Asynchronous reset between floors 1 and 2.
    applyReset();
    applyStimulus(4'b0100, 1);
    waitNeg(7);
    checkOutput("assinc_antes", 32'(vista), 32'({4'b0100, 4'b1000, 2'd1}));
    #2 rst_n = 1'b0;
    #1 checkOutput("assinc_reset", 32'(vista), 32'h0);
    waitNeg(1);
    rst_n = 1'b1;
    waitNeg(2);
    checkOutput("assinc_depois", 32'(vista), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevador_controle.md
Name: elevador_controle

Overview:
- Sequential controller for the 4-floor elevator car; replaces free-running combinational up/down/door decoding with latched call requests, a floor register and timed door and travel phases.
- Registers button calls, runs a SCAN-style direction policy (keep direction while calls remain ahead) and emits one-hot Moore commands Su/De/PA/PF to the motor and door drivers.

Parameters:
- N_ANDARES, 4, number of floors; the floor code is 2 bits wide. Only 4 is supported.
- T_VIAGEM, 4, clock cycles to travel one floor (must be at least 1).
- T_PORTA, 3, clock cycles the door stays open (must be at least 1).
- T_FECHA, 2, clock cycles of the door-closing phase (must be at least 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chamadas  in  4  call buttons; bit 0 = At (ground), bits 1..3 = A1..A3. A level high in any cycle registers that call.
- andar  out  2  current floor; {AndarB1, AndarB0} encoding.
- pendentes  out  4  latched outstanding calls.
- Su  out  1  motor up command.
- De  out  1  motor down command.
- PA  out  1  door open command.
- PF  out  1  door closing command.

Behaviour:
- Reset (async, rst_n=0):
  - state=PARADO, andar=0, pendentes=0, dir=SOBE, timer=0.
  - Su=De=PA=PF=0.
  - Release is synchronous to clk.
- States: PARADO, SUBINDO, DESCENDO, PORTA_ABERTA, PORTA_FECHANDO.
- Outputs are decoded from the state register only (Moore), so they are glitch-free:
  - Su=1 only in SUBINDO; De=1 only in DESCENDO.
  - PA=1 only in PORTA_ABERTA; PF=1 only in PORTA_FECHANDO.
  - At most one of the four is high in any cycle.
- Call latching:
  - pendentes[i] is set at the edge after chamadas[i]=1.
  - A call to the current floor while in PORTA_ABERTA is not latched; it reloads the door timer to T_PORTA.
  - A call to the current floor while in PORTA_FECHANDO is not latched; it moves the FSM to PORTA_ABERTA with the timer at T_PORTA (reopen).
- "Acima" means any pendentes bit above andar; "abaixo" means any bit below andar.
- PARADO transitions, in priority order:
  1. pendentes[andar] set -> PORTA_ABERTA; clear that bit; timer=T_PORTA.
  2. Else, if acima and (dir=SOBE or not abaixo) -> SUBINDO; dir=SOBE; timer=T_VIAGEM.
  3. Else, if abaixo -> DESCENDO; dir=DESCE; timer=T_VIAGEM.
  4. Else stay in PARADO.
- SUBINDO / DESCENDO:
  - The timer decrements each cycle.
  - On the edge where the timer reaches 1, andar becomes andar±1 and, with the new floor n:
    - pendentes[n] set (including a call arriving that same cycle) -> PORTA_ABERTA; clear bit n; timer=T_PORTA.
    - Else, calls remain ahead in the current direction -> stay in the same state; timer=T_VIAGEM.
    - Else -> PARADO.
  - andar never wraps: SUBINDO is only entered with acima true and DESCENDO only with abaixo true. Reaching floor 3 going up or floor 0 going down therefore ends travel.
- PORTA_ABERTA: when the timer expires -> PORTA_FECHANDO; timer=T_FECHA.
- PORTA_FECHANDO: when the timer expires -> PARADO, unless a reopen occurs (see call latching).
- Latency: a call pulse at edge k sets pendentes; PARADO evaluates the call and the new state is visible after edge k+1.
- Simultaneous events:
  - Several calls in the same cycle are all latched.
  - The clear of the current floor's bit has priority over the set of that bit in the same cycle.
- Reset mid-travel or with the door open returns to floor 0 immediately. No position is retained; the floor register is the only position source.

Decomposition:
- Package elevador_pkg:
  - estado_t enum (5 states).
  - dir_t (SOBE, DESCE).
  - N_ANDARES constant.
  - Floor-code localparams for floors 0..3.
- Sub-module elevador_temporizador:
  - Loadable down-counter with carga/valor/fim.
  - Width $clog2(max(T_VIAGEM, T_PORTA, T_FECHA)+1).
  - Shared by all timed states.
- FSM, call register and direction logic stay in elevador_controle.

Test Plan:
- Call for floor 2 with defaults (T_VIAGEM=4, T_PORTA=3, T_FECHA=2):
  - Stimulus: reset, then chamadas=4'b0100 for 1 cycle.
  - Expected: Su high for 8 cycles; andar=1 after 4 cycles and andar=2 after 8.
  - Then PA=1 for 3 cycles, PF=1 for 2 cycles, PARADO.
  - pendentes[2] clears on the PA entry edge.
- Call for the current floor in PARADO:
  - Stimulus: with andar=0, chamadas=4'b0001.
  - Expected: PA rises at edge k+1; Su/De stay 0; pendentes returns to 0.
- SCAN ordering:
  - Stimulus: at floor 1 moving up, latch calls for floors 3 and 0 together.
  - Expected: serve floor 3 first (Su), then reverse to floor 0 (De). Observed andar sequence: 2, 3, 2, 1, 0.
- Door reopen:
  - Stimulus: during PORTA_FECHANDO at floor 2, chamadas=4'b0100.
  - Expected: next cycle PA=1, PF=0; PA then holds for a full 3 cycles; pendentes stays 0.
- Door hold:
  - Stimulus: in PORTA_ABERTA, repeat the current-floor call each cycle.
  - Expected: PA stays high indefinitely; PF never asserts.
- Async reset mid-travel:
  - Stimulus: drop rst_n while in SUBINDO between floors 1 and 2.
  - Expected: andar=0, all outputs 0, pendentes=0 immediately, without waiting for a clock edge.
